fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer that owns the program counter and schedules instruction-cache requests. It arbitrates PC redirects from CSR and execute, sequences I-cache flushes, parks fetch during WFI, and raises fetch exceptions. It sits between the CSR/execute feedback paths and the I-cache. It delivers one registered instruction per cycle to decode.

## Interface
Parameters:
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, PC loaded at reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- csr_redirect_i  in  1  CSR new-PC request (trap/mret)
- csr_pc_i  in  XLEN  CSR target PC
- exe_redirect_i  in  1  execute new-PC request (branch/jump)
- exe_pc_i  in  XLEN  execute target PC; also resume PC for WFI
- wfi_i  in  1  WFI retired; enter sleep
- irq_i  in  1  pending interrupt (level)
- flush_i  in  1  I-cache flush request (fence.i), 1-cycle pulse
- stall_i  in  1  decode cannot accept
- ic_req_o  out  1  I-cache read request
- ic_addr_o  out  XLEN  request address (= pc)
- ic_ack_i  in  1  read data valid for ic_addr_o this cycle
- ic_data_i  in  32  instruction
- ic_pf_i  in  1  page fault, qualified by ic_ack_i
- ic_flush_o  out  1  flush request to I-cache
- ic_flush_ack_i  in  1  flush complete
- id_valid_o  out  1  decode slot valid
- id_pc_o  out  XLEN  PC of slot
- id_instr_o  out  32  instruction of slot
- id_exc_o  out  1  slot carries exception
- id_cause_o  out  4  exception cause (0 = misaligned, 12 = page fault)

## Operation
- States: RUN, FLUSH, WFI, EXC. Reset: state=RUN, pc=RESET_PC, all id_* = 0, ic_req_o=0, ic_flush_o=0.
- PC source priority: csr_redirect_i > exe_redirect_i. A redirect is accepted in any state. It loads pc at the next edge. id_valid_o is cleared at the next edge, even when stall_i=1. A same-cycle ic_ack_i is discarded.
- Next-state priority on a cycle with events: flush_i -> FLUSH; else wfi_i -> WFI (pc <= exe_pc_i); else a redirect -> RUN (this also leaves EXC and WFI).
- RUN:
  - If pc[1:0] != 0: no request is issued. At the next edge, when not stalled: id_valid=1, id_exc=1, cause=0, id_pc=pc. State -> EXC.
  - Otherwise ic_req_o = !stall_i. When ic_req_o and ic_ack_i and no redirect: id_pc=pc, id_instr=ic_data_i, id_valid=1, and pc <= pc+4, all at the next edge.
  - If ic_pf_i is set with the ack: id_exc=1, cause=12, pc is held, and state -> EXC.
  - If no ack arrives and stall_i=0: id_valid <= 0.
- stall_i=1: all id_* hold and pc holds (redirects excepted).
- EXC: no requests. id slot held until consumed (!stall_i), then id_valid <= 0. Exit only on a redirect.
- FLUSH: ic_req_o=0 and ic_flush_o=1 until the cycle ic_flush_ack_i=1. At the next edge -> RUN; a redirect then takes effect. id_valid <= 0 on entry.
- WFI: ic_req_o=0. irq_i=1 or a redirect -> RUN at the next edge. pc = exe_pc_i captured on entry, unless a redirect overrides it.
- pc+4 wraps modulo 2^XLEN.

## Timing
- Zero-wait cache: req at t, ack at t, instruction on id_* at t+1. Throughput 1 instr/cycle.
- Redirect at t: ic_addr_o = new PC at t+1. The first redirected instruction is valid at t+2 with zero-wait.
- Flush: ic_flush_o rises at t+1 after flush_i. The first fetch request occurs the cycle after ic_flush_ack_i.
- WFI exit: irq_i at t -> ic_req_o at t+1.
- rst asserted mid-operation: reset values apply at the next edge, and any in-flight ack is ignored.

## Structure
- Shared package fetch_ctrl_pkg:
  - state enum type_fetch_ctrl_state_e
  - cause constants EXC_INSTR_MISALIGN=4'd0 and EXC_INSTR_PAGE_FAULT=4'd12
  - typedef type_fetch_slot_s bundling valid/pc/instr/exc/cause
- One sub-module is natural: fetch_pc_mux. It is combinational next-PC selection (RESET_PC, csr, exe, pc+4, hold), kept separate for unit testing.

## Test plan
- Reset, then ic_ack_i held 1 with data 32'h00000013 -> ic_addr_o = 0, 4, 8 on consecutive cycles; id_valid_o=1 from cycle 2 with id_pc 0, 4, 8.
- csr_redirect_i and exe_redirect_i together at pc=0x8, with csr_pc=0x20 and exe_pc=0x40 -> next ic_addr_o=0x20; the ack in the redirect cycle is not delivered.
- exe redirect to 0x3 -> no ic_req_o; id_exc_o=1, cause 0, id_pc 0x3. Held in EXC until csr_redirect_i to 0x100, then fetch resumes at 0x100.
- ic_ack_i with ic_pf_i=1 at pc=0xDEADBEEC -> id_exc_o=1, cause 12, pc held; no further requests until a redirect.
- flush_i pulse, with ic_flush_ack_i asserted 3 cycles later -> ic_flush_o high for exactly those cycles, ic_req_o=0 throughout, and fetch resumes the cycle after the ack.
- wfi_i with exe_pc_i=0x44 -> ic_req_o=0 until irq_i; irq_i at t gives ic_addr_o=0x44 with ic_req_o at t+1. Separately, stall_i=1 for 2 cycles holds id_* and pc unchanged.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types and constants for the fetch-stage sequencer:
//               FSM states, exception causes, next-PC selects and the
//               decode-slot bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    // State encodings, kept explicit so the register width is fixed
    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_FLUSH = 2'd1;
    localparam logic [1:0] c_ST_WFI   = 2'd2;
    localparam logic [1:0] c_ST_EXC   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = c_ST_RUN,
        ST_FLUSH = c_ST_FLUSH,
        ST_WFI   = c_ST_WFI,
        ST_EXC   = c_ST_EXC
    } type_fetch_ctrl_state_e;

    // Exception causes reported with a decode slot
    localparam logic [3:0] EXC_INSTR_MISALIGN   = 4'd0;
    localparam logic [3:0] EXC_INSTR_PAGE_FAULT = 4'd12;

    // Widest PC the slot bundle can carry; narrower XLEN zero-extends
    localparam int unsigned c_SLOT_PC_W = 64;

    // Next-PC source selection
    typedef enum logic [2:0] {
        PC_SEL_RESET = 3'd0,
        PC_SEL_CSR   = 3'd1,
        PC_SEL_EXE   = 3'd2,
        PC_SEL_INC   = 3'd3,
        PC_SEL_HOLD  = 3'd4
    } type_pc_sel_e;

    // One decode slot
    typedef struct packed {
        logic                   valid;
        logic [c_SLOT_PC_W-1:0] pc;
        logic [31:0]            instr;
        logic                   exc;
        logic [3:0]             cause;
    } type_fetch_slot_s;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_mux.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_mux
// Description : Combinational next-PC selection: reset vector, CSR target,
//               execute target, sequential pc+4 (wrapping) or hold.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_mux
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  type_pc_sel_e        i_sel,
    input  logic [XLEN-1:0]     i_pc,
    input  logic [XLEN-1:0]     i_csr_pc,
    input  logic [XLEN-1:0]     i_exe_pc,
    output logic [XLEN-1:0]     o_next_pc
);

    // Select the PC to be loaded at the next edge; pc+4 wraps naturally
    always_comb begin
        o_next_pc = i_pc;
        case (i_sel)
            PC_SEL_RESET: o_next_pc = RESET_PC;
            PC_SEL_CSR:   o_next_pc = i_csr_pc;
            PC_SEL_EXE:   o_next_pc = i_exe_pc;
            PC_SEL_INC:   o_next_pc = i_pc + XLEN'(4);
            default:      o_next_pc = i_pc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch-stage sequencer. Owns the PC, issues I-cache reads,
//               arbitrates CSR/execute redirects, sequences I-cache flushes,
//               parks during WFI and raises fetch exceptions into a
//               registered decode slot.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_redirect_i,
    input  logic [XLEN-1:0]     csr_pc_i,
    input  logic                exe_redirect_i,
    input  logic [XLEN-1:0]     exe_pc_i,
    input  logic                wfi_i,
    input  logic                irq_i,
    input  logic                flush_i,
    input  logic                stall_i,
    output logic                ic_req_o,
    output logic [XLEN-1:0]     ic_addr_o,
    input  logic                ic_ack_i,
    input  logic [31:0]         ic_data_i,
    input  logic                ic_pf_i,
    output logic                ic_flush_o,
    input  logic                ic_flush_ack_i,
    output logic                id_valid_o,
    output logic [XLEN-1:0]     id_pc_o,
    output logic [31:0]         id_instr_o,
    output logic                id_exc_o,
    output logic [3:0]          id_cause_o
);

    type_fetch_ctrl_state_e     r_state;
    type_fetch_ctrl_state_e     w_state_nxt;
    logic [XLEN-1:0]            r_pc;
    logic [XLEN-1:0]            w_pc_nxt;
    type_pc_sel_e               w_pc_sel;
    type_fetch_slot_s           r_slot;
    type_fetch_slot_s           w_slot_load;
    logic [c_SLOT_PC_W-1:0]     w_pc_ext;
    logic                       w_redirect;
    logic                       w_event;
    logic                       w_run;
    logic                       w_misaligned;
    logic                       w_accept;
    logic                       w_raise_misalign;
    logic                       w_unused_slot_pc;

    // Request/flush strobes and the qualifiers shared by the other processes
    always_comb begin
        w_redirect       = csr_redirect_i | exe_redirect_i;
        w_event          = w_redirect | flush_i | wfi_i;
        w_run            = (r_state == ST_RUN);
        w_misaligned     = |r_pc[1:0];
        ic_req_o         = !rst && w_run && !w_misaligned && !stall_i;
        ic_flush_o       = !rst && (r_state == ST_FLUSH);
        // Any redirect/flush/WFI in the same cycle discards the ack
        w_accept         = ic_req_o && ic_ack_i && !w_event;
        w_raise_misalign = w_run && w_misaligned && !stall_i && !w_event;
    end

    // Next-PC source: CSR beats execute, WFI captures the resume PC
    always_comb begin
        w_pc_sel = PC_SEL_HOLD;
        if (rst)                       w_pc_sel = PC_SEL_RESET;
        else if (csr_redirect_i)       w_pc_sel = PC_SEL_CSR;
        else if (exe_redirect_i)       w_pc_sel = PC_SEL_EXE;
        else if (wfi_i)                w_pc_sel = PC_SEL_EXE;
        else if (w_accept && !ic_pf_i) w_pc_sel = PC_SEL_INC;
    end

    fetch_pc_mux #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_mux (
        .i_sel     (w_pc_sel),
        .i_pc      (r_pc),
        .i_csr_pc  (csr_pc_i),
        .i_exe_pc  (exe_pc_i),
        .o_next_pc (w_pc_nxt)
    );

    // PC register
    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_nxt;
    end

    // Next-state: flush, then WFI, then flush completion, then redirects
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_FLUSH;
        end else if (wfi_i) begin
            w_state_nxt = ST_WFI;
        end else if (r_state == ST_FLUSH) begin
            // A redirect during a flush only moves the PC; the flush completes first
            if (ic_flush_ack_i) w_state_nxt = ST_RUN;
        end else if (w_redirect) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_raise_misalign || (w_accept && ic_pf_i)) w_state_nxt = ST_EXC;
                end
                ST_WFI: begin
                    if (irq_i) w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Build the slot that would be loaded this cycle
    always_comb begin
        w_pc_ext              = '0;
        w_pc_ext[XLEN-1:0]    = r_pc;
        w_slot_load           = '0;
        w_slot_load.valid     = 1'b1;
        w_slot_load.pc        = w_pc_ext;
        if (w_misaligned) begin
            w_slot_load.exc   = 1'b1;
            w_slot_load.cause = EXC_INSTR_MISALIGN;
        end else if (ic_pf_i) begin
            w_slot_load.exc   = 1'b1;
            w_slot_load.cause = EXC_INSTR_PAGE_FAULT;
        end else begin
            w_slot_load.instr = ic_data_i;
        end
    end

    // Decode slot: redirects/flush drop it, a stall holds it, else load or drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else if (w_redirect || flush_i) begin
            r_slot.valid <= 1'b0;
        end else if (!stall_i) begin
            if (w_raise_misalign || w_accept) r_slot <= w_slot_load;
            else                              r_slot.valid <= 1'b0;
        end
    end

    // Upper slot PC bits are zero when XLEN is narrower than the bundle
    assign w_unused_slot_pc = ^r_slot.pc;

    assign ic_addr_o  = r_pc;
    assign id_valid_o = r_slot.valid;
    assign id_pc_o    = r_slot.pc[XLEN-1:0];
    assign id_instr_o = r_slot.instr;
    assign id_exc_o   = r_slot.exc;
    assign id_cause_o = r_slot.cause;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. Directed scenarios then
//               random traffic; a transaction-level reference model predicts
//               request/flush strobes per cycle and queues every expected
//               decode slot, which a separate monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int unsigned     XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            csr_redirect_i, exe_redirect_i, wfi_i, irq_i, flush_i, stall_i;
    logic [XLEN-1:0] csr_pc_i, exe_pc_i;
    logic            ic_req_o, ic_ack_i, ic_pf_i, ic_flush_o, ic_flush_ack_i;
    logic [XLEN-1:0] ic_addr_o, id_pc_o;
    logic [31:0]     ic_data_i, id_instr_o;
    logic            id_valid_o, id_exc_o;
    logic [3:0]      id_cause_o;

    always #5 clk = ~clk;

    fetch_ctrl #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .csr_redirect_i(csr_redirect_i), .csr_pc_i(csr_pc_i),
        .exe_redirect_i(exe_redirect_i), .exe_pc_i(exe_pc_i),
        .wfi_i(wfi_i), .irq_i(irq_i), .flush_i(flush_i), .stall_i(stall_i),
        .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o), .ic_ack_i(ic_ack_i),
        .ic_data_i(ic_data_i), .ic_pf_i(ic_pf_i),
        .ic_flush_o(ic_flush_o), .ic_flush_ack_i(ic_flush_ack_i),
        .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_instr_o(id_instr_o),
        .id_exc_o(id_exc_o), .id_cause_o(id_cause_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  cause;
    } exp_slot_t;

    typedef enum {FETCHING, FLUSHING, SLEEPING, TRAPPED} mode_e;

    exp_slot_t   exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    mode_e       m_mode   = FETCHING;
    logic [31:0] m_pc     = RESET_PC;
    logic        m_valid  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; csr_redirect_i = 1'b0; exe_redirect_i = 1'b0;
        wfi_i = 1'b0; irq_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        ic_ack_i = 1'b0; ic_pf_i = 1'b0; ic_flush_ack_i = 1'b0;
        csr_pc_i = '0; exe_pc_i = '0; ic_data_i = $urandom;
    endtask

    // One clock: check strobes against the model, advance the model, clock
    task automatic cycle();
        logic        redir, quiet, exp_req, delivered;
        logic [31:0] tgt;
        #1;
        redir     = csr_redirect_i | exe_redirect_i;
        tgt       = csr_redirect_i ? csr_pc_i : exe_pc_i;
        quiet     = !(redir | flush_i | wfi_i);
        exp_req   = !rst && (m_mode == FETCHING) && (m_pc[1:0] == 2'b00) && !stall_i;
        delivered = 1'b0;
        check("ic_req", ic_req_o, exp_req);
        check("ic_flush", ic_flush_o, !rst && (m_mode == FLUSHING));
        if (!rst) check("ic_addr", ic_addr_o, m_pc);
        if (rst) begin
            m_mode  = FETCHING;
            m_pc    = RESET_PC;
            m_valid = 1'b0;
        end else begin
            if (quiet && m_mode == FETCHING && !stall_i) begin
                if (m_pc[1:0] != 2'b00) begin
                    exp_q.push_back({m_pc, 32'h0, 1'b1, 4'd0});
                    m_mode = TRAPPED;
                    delivered = 1'b1;
                end else if (ic_ack_i) begin
                    delivered = 1'b1;
                    if (ic_pf_i) begin
                        exp_q.push_back({m_pc, 32'h0, 1'b1, 4'd12});
                        m_mode = TRAPPED;
                    end else begin
                        exp_q.push_back({m_pc, ic_data_i, 1'b0, 4'd0});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            if (redir)      m_pc = tgt;
            else if (wfi_i) m_pc = exe_pc_i;
            if (flush_i)                 m_mode = FLUSHING;
            else if (wfi_i)              m_mode = SLEEPING;
            else if (m_mode == FLUSHING) begin
                if (ic_flush_ack_i) m_mode = FETCHING;
            end
            else if (redir)              m_mode = FETCHING;
            else if (m_mode == SLEEPING && irq_i) m_mode = FETCHING;
            if (redir || flush_i) m_valid = 1'b0;
            else if (delivered)   m_valid = 1'b1;
            else if (!stall_i)    m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("id_valid", id_valid_o, m_valid);
    endtask

    // Monitor: a slot is new when nothing was shown or the last one was consumed
    initial begin : monitor
        logic      prev_valid;
        logic      prev_stall;
        exp_slot_t cur;
        exp_slot_t e;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        cur        = '0;
        forever begin
            @(negedge clk);
            if (id_valid_o === 1'b1) begin
                if (!prev_valid || !prev_stall) begin
                    if (exp_q.size() == 0) begin
                        check("slot_unexpected", {32'h0, id_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e   = exp_q.pop_front();
                        cur = e;
                    end
                end
                check("slot_pc", id_pc_o, cur.pc);
                check("slot_instr", id_instr_o, cur.instr);
                check("slot_exc", id_exc_o, cur.exc);
                check("slot_cause", id_cause_o, cur.cause);
            end
            prev_valid = (id_valid_o === 1'b1);
            prev_stall = stall_i;
        end
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 9) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    initial begin : stimulus
        int r;
        idle();
        rst = 1'b1;
        cycle(); cycle(); cycle();
        // Reset state, still under reset
        check("rst_id_valid", id_valid_o, 1'b0);
        check("rst_id_pc", id_pc_o, 32'h0);
        check("rst_id_instr", id_instr_o, 32'h0);
        check("rst_id_exc", id_exc_o, 1'b0);
        check("rst_id_cause", id_cause_o, 4'd0);
        check("rst_ic_req", ic_req_o, 1'b0);
        check("rst_ic_flush", ic_flush_o, 1'b0);
        check("rst_ic_addr", ic_addr_o, RESET_PC);

        // Zero-wait streaming: 0, 4, then redirect with both sources at pc 8
        idle(); ic_ack_i = 1'b1; ic_data_i = 32'h0000_0013; cycle();
        ic_data_i = 32'h0000_0013; cycle();
        csr_redirect_i = 1'b1; csr_pc_i = 32'h20; exe_redirect_i = 1'b1; exe_pc_i = 32'h40;
        cycle();
        check("redirect_addr", ic_addr_o, 32'h20);
        idle(); ic_ack_i = 1'b1; cycle(); cycle();

        // Misaligned target, trapped until a CSR redirect
        idle(); exe_redirect_i = 1'b1; exe_pc_i = 32'h3; cycle();
        idle(); ic_ack_i = 1'b1; cycle(); cycle(); cycle();
        check("misalign_exc", id_exc_o, 1'b1);
        idle(); csr_redirect_i = 1'b1; csr_pc_i = 32'h100; cycle();
        idle(); ic_ack_i = 1'b1; cycle(); cycle();

        // Page fault, then redirect out
        idle(); exe_redirect_i = 1'b1; exe_pc_i = 32'hDEAD_BEEC; cycle();
        idle(); ic_ack_i = 1'b1; ic_pf_i = 1'b1; cycle();
        check("pf_cause", id_cause_o, 4'd12);
        idle(); ic_ack_i = 1'b1; cycle(); cycle();
        idle(); exe_redirect_i = 1'b1; exe_pc_i = 32'h200; cycle();
        idle(); ic_ack_i = 1'b1; cycle();

        // Flush with the ack three cycles after the request
        idle(); flush_i = 1'b1; cycle();
        idle(); cycle(); cycle();
        ic_flush_ack_i = 1'b1; cycle();
        idle(); ic_ack_i = 1'b1; cycle(); cycle();

        // WFI, wake on interrupt
        idle(); wfi_i = 1'b1; exe_pc_i = 32'h44; cycle();
        idle(); ic_ack_i = 1'b1; cycle(); cycle(); cycle();
        irq_i = 1'b1; cycle();
        check("wfi_wake_addr", ic_addr_o, 32'h44);
        idle(); ic_ack_i = 1'b1; cycle(); cycle();

        // Stall holds the slot and the PC
        stall_i = 1'b1; cycle(); cycle();
        check("stall_pc_hold", ic_addr_o, 32'h4C);
        idle(); ic_ack_i = 1'b1; cycle();

        // PC wraps at the top of the address space
        idle(); exe_redirect_i = 1'b1; exe_pc_i = 32'hFFFF_FFF8; cycle();
        idle(); ic_ack_i = 1'b1; cycle(); cycle(); cycle();

        // Reset mid-stream with an ack in flight
        rst = 1'b1; cycle();
        idle(); ic_ack_i = 1'b1; cycle(); cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            r              = $urandom_range(0, 99);
            ic_ack_i       = ($urandom_range(0, 9) < 7);
            ic_pf_i        = ($urandom_range(0, 19) == 0);
            stall_i        = ($urandom_range(0, 3) == 0);
            irq_i          = ($urandom_range(0, 9) == 0);
            ic_flush_ack_i = ($urandom_range(0, 3) == 0);
            exe_pc_i       = rand_pc();
            csr_pc_i       = rand_pc();
            if (r < 3)                 csr_redirect_i = 1'b1;
            else if (r < 8)            exe_redirect_i = 1'b1;
            else if (r < 10)           wfi_i = 1'b1;
            else if (r == 10)          flush_i = 1'b1;
            else if (r == 11) begin    csr_redirect_i = 1'b1; exe_redirect_i = 1'b1; end
            else if (r == 12)          rst = 1'b1;
            cycle();
        end

        // Drain and confirm every predicted slot was presented
        idle(); cycle(); cycle(); cycle();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
